// File: rtl/phase_noise_pkg.sv
// Shared types, constants and helpers for the phase-noise-analyzer datapath.
package phase_noise_pkg;

  localparam int RATE_MIN       = 2;
  localparam int DROP_CNT_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } decim_state_e;

  // Sign-extend the low w bits of raw to 64 bits; callers truncate to their width.
  function automatic logic signed [63:0] sext(input logic [63:0] raw, input int unsigned w);
    logic signed [63:0] t;
    t = $signed(raw << (64 - w));
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/phase_decimator_if.sv
// Sample-in / block-sum-out bundle of the phase decimator.
// Handshake: a result moves on every rising edge where dout_valid && dout_ready;
// once dout_valid is high, dout and dout_valid hold until that transfer happens.
interface phase_decimator_if #(
  parameter int DIN_WIDTH  = 17,
  parameter int DOUT_WIDTH = 40,
  parameter int RATE_WIDTH = 16
);
  import phase_noise_pkg::*;

  logic [DIN_WIDTH-1:0]      din;
  logic                      din_valid;
  logic [RATE_WIDTH-1:0]     rate;
  logic                      realign;
  logic [DOUT_WIDTH-1:0]     dout;
  logic                      dout_valid;
  logic                      dout_ready;
  logic [DROP_CNT_WIDTH-1:0] drop_count;
  logic                      busy;

  modport slave (
    input  din, din_valid, rate, realign, dout_ready,
    output dout, dout_valid, drop_count, busy
  );

  modport master (
    output din, din_valid, rate, realign, dout_ready,
    input  dout, dout_valid, drop_count, busy
  );
endinterface

// File: rtl/phase_decimator_out_reg.sv
// Single-entry output register: valid/ready hold, overrun detection and a
// saturating count of results lost while the consumer stalls.
module decim_out_reg
  import phase_noise_pkg::*;
#(
  parameter int WIDTH = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [WIDTH-1:0]          data,
  input  logic                      ready,
  output logic [WIDTH-1:0]          dout,
  output logic                      valid,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  logic [WIDTH-1:0]          dout_q;
  logic                      valid_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic                      xfer;
  logic                      overrun;

  assign xfer    = valid_q && ready;
  // A result arriving while the held one is stalled is lost, never overwrites.
  assign overrun = load && valid_q && !ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (load && !overrun) begin
        dout_q  <= data;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      if (overrun && drop_q != {DROP_CNT_WIDTH{1'b1}}) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign drop_count = drop_q;

endmodule

// File: rtl/phase_decimator.sv
// Boxcar decimator: sums R valid frequency words per block and hands each
// block sum to the output register; rate is latched at block start.
module phase_decimator
  import phase_noise_pkg::*;
#(
  parameter int DIN_WIDTH  = 17,
  parameter int DOUT_WIDTH = 40,
  parameter int RATE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  phase_decimator_if.slave     bus,
  output decim_state_e         fsm_state
);

  decim_state_e              state, state_n;
  logic [DOUT_WIDTH-1:0]     acc, acc_n;
  logic [RATE_WIDTH-1:0]     cnt, cnt_n;
  logic [RATE_WIDTH-1:0]     r_lat, r_lat_n;
  logic [RATE_WIDTH-1:0]     rate_clamp;
  logic [DOUT_WIDTH-1:0]     din_ext;
  logic [DOUT_WIDTH-1:0]     sum;
  logic                      close;

  assign din_ext    = DOUT_WIDTH'(sext(64'(bus.din), DIN_WIDTH));
  assign sum        = acc + din_ext;
  assign rate_clamp = (bus.rate < RATE_WIDTH'(RATE_MIN)) ? RATE_WIDTH'(RATE_MIN) : bus.rate;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      r_lat <= RATE_WIDTH'(RATE_MIN);
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      r_lat <= r_lat_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    r_lat_n = r_lat;
    close   = 1'b0;
    if (bus.realign) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
    end else if (bus.din_valid) begin
      // cnt == 0 in RUN means the previous block just closed: start a new one.
      if (state == IDLE || cnt == '0) begin
        state_n = RUN;
        acc_n   = din_ext;
        cnt_n   = RATE_WIDTH'(1);
        r_lat_n = rate_clamp;
      end else if (cnt == r_lat - RATE_WIDTH'(1)) begin
        close = 1'b1;
        acc_n = '0;
        cnt_n = '0;
      end else begin
        acc_n = sum;
        cnt_n = cnt + RATE_WIDTH'(1);
      end
    end
  end

  decim_out_reg #(
    .WIDTH(DOUT_WIDTH)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (close),
    .data       (sum),
    .ready      (bus.dout_ready),
    .dout       (bus.dout),
    .valid      (bus.dout_valid),
    .drop_count (bus.drop_count)
  );

  assign bus.busy  = (state == RUN) && (cnt != '0);
  assign fsm_state = state;

endmodule

// File: tb/tb_phase_decimator.sv
// Directed table-driven bench for phase_decimator plus hand-written
// sequences for drop-counter saturation and mid-block reset.
module tb_phase_decimator;
  import phase_noise_pkg::*;

  localparam int DW = 17;
  localparam int OW = 40;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decim_state_e fsm_state;

  phase_decimator_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .RATE_WIDTH(RW)) bus ();

  phase_decimator #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .RATE_WIDTH(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 dv;
    logic signed [DW-1:0] din;
    logic [RW-1:0]        rate;
    logic                 realign;
    logic                 ready;
    logic                 ev;
    logic signed [OW-1:0] ed;
    logic [15:0]          edrop;
    logic                 eb;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void add(input logic dv, input int din, input int rate, input logic realign,
                              input logic ready, input logic ev, input longint ed,
                              input int edrop, input logic eb);
    vec_t v;
    v.dv = dv; v.din = DW'(din); v.rate = RW'(rate); v.realign = realign; v.ready = ready;
    v.ev = ev; v.ed = OW'(ed); v.edrop = 16'(edrop); v.eb = eb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input logic [DW-1:0] din, input logic [RW-1:0] rate,
                       input logic realign, input logic ready);
    bus.din_valid  = dv;
    bus.din        = din;
    bus.rate       = rate;
    bus.realign    = realign;
    bus.dout_ready = ready;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [OW-1:0] ed,
                            input logic [15:0] edrop, input logic eb);
    check({tag, ".dout_valid"}, 64'(bus.dout_valid), 64'(ev));
    check({tag, ".dout"},       64'(bus.dout),       64'(ed));
    check({tag, ".drop_count"}, 64'(bus.drop_count), 64'(edrop));
    check({tag, ".busy"},       64'(bus.busy),       64'(eb));
  endtask

  initial begin
    logic [15:0] exp_drop;

    drive(1'b0, '0, 16'd4, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, '0, 16'd0, 1'b0);
    check("reset.state", 64'(fsm_state), 64'(IDLE));
    rst = 1'b0;

    // R=4, 1..8 contiguous: 10 then 26
    add(1,1,4,0,1, 0,0,0,1);   add(1,2,4,0,1, 0,0,0,1);
    add(1,3,4,0,1, 0,0,0,1);   add(1,4,4,0,1, 1,10,0,0);
    add(1,5,4,0,1, 0,10,0,1);  add(1,6,4,0,1, 0,10,0,1);
    add(1,7,4,0,1, 0,10,0,1);  add(1,8,4,0,1, 1,26,0,0);
    add(0,0,4,0,1, 0,26,0,0);
    // R=1 clamps to 2, din -3
    add(1,-3,1,0,1, 0,26,0,1); add(1,-3,1,0,1, 1,-6,0,0);
    add(1,-3,1,0,1, 0,-6,0,1); add(1,-3,1,0,1, 1,-6,0,0);
    add(0,0,1,0,1, 0,-6,0,0);
    // R=3 with gaps
    add(1,100,3,0,1, 0,-6,0,1);  add(0,0,3,0,1, 0,-6,0,1);
    add(1,100,3,0,1, 0,-6,0,1);  add(0,0,3,0,1, 0,-6,0,1);
    add(1,100,3,0,1, 1,300,0,0); add(0,0,3,0,1, 0,300,0,0);
    // R=2 with back-pressure: 5 held, 7 and 9 dropped
    add(1,2,2,0,0, 0,300,0,1); add(1,3,2,0,0, 1,5,0,0);
    add(1,3,2,0,0, 1,5,0,1);   add(1,4,2,0,0, 1,5,1,0);
    add(1,4,2,0,0, 1,5,1,1);   add(1,5,2,0,0, 1,5,2,0);
    add(0,0,2,0,1, 0,5,2,0);
    add(1,6,2,0,1, 0,5,2,1);   add(1,7,2,0,1, 1,13,2,0);
    add(0,0,2,0,1, 0,13,2,0);
    // R=4 realign after 2 samples, then 4 x -8
    add(1,50,4,0,1, 0,13,2,1);  add(1,60,4,0,1, 0,13,2,1);
    add(1,99,4,1,1, 0,13,2,0);
    add(1,-8,4,0,1, 0,13,2,1);  add(1,-8,4,0,1, 0,13,2,1);
    add(1,-8,4,0,1, 0,13,2,1);  add(1,-8,4,0,1, 1,-32,2,0);
    add(0,0,4,0,1, 0,-32,2,0);
    // R=2 realign on the closing sample: no result
    add(1,-8,2,0,1, 0,-32,2,1); add(1,7,2,1,1, 0,-32,2,0);
    add(1,1,2,0,1, 0,-32,2,1);  add(0,0,2,1,1, 0,-32,2,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dv, vecs[i].din, vecs[i].rate, vecs[i].realign, vecs[i].ready);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].edrop, vecs[i].eb);
    end

    // Saturation: fill the output, preload the counter, then keep overrunning
    drive(1'b1, DW'(1), 16'd2, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("sat.first", 1'b1, OW'(2), 16'd2, 1'b0);
    force dut.u_out.drop_q = 16'hFFF0;
    #1;
    release dut.u_out.drop_q;
    exp_drop = 16'hFFF0;
    for (int b = 0; b < 20; b++) begin
      repeat (2) @(posedge clk);
      #1;
      if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      check_outs($sformatf("sat.blk%0d", b), 1'b1, OW'(2), exp_drop, 1'b0);
    end
    check("sat.final", 64'(bus.drop_count), 64'h0000_0000_0000_FFFF);

    // Reset mid-block with a pending output
    @(posedge clk);
    #1;
    check("mid.busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outs("rst_mid", 1'b0, '0, 16'd0, 1'b0);
    check("rst_mid.state", 64'(fsm_state), 64'(IDLE));
    rst = 1'b0;
    drive(1'b0, '0, 16'd2, 1'b0, 1'b1);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
